// File: rtl/naive_bus_arbiter2_if.sv
// naive_bus: split read/write request-grant bus shared by masters and slaves
interface naive_bus;
    logic        rd_req, rd_gnt, wr_req, wr_gnt;
    logic [3:0]  rd_be, wr_be;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
    modport master (output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                    input rd_gnt, wr_gnt, rd_data);
    modport slave (input rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
                   output rd_gnt, wr_gnt, rd_data);
endinterface

// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2: two-master to one-slave naive_bus arbiter with stall lock and burst guard
module naive_bus_arbiter2 #(
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 8
) (
    input  logic     clk,
    input  logic     rst,
    naive_bus.slave  m0,
    naive_bus.slave  m1,
    naive_bus.master s,
    output logic     o_owner,
    output logic     o_busy
);
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);
    state_t state, state_n;
    logic owner, sel, last_gnt, rd_owner, rd_valid;
    logic req0, req1, rd_fwd, wr_fwd, rd_grant, wr_grant;
    logic [7:0] burst_cnt;
    assign req0 = m0.rd_req | m0.wr_req;
    assign req1 = m1.rd_req | m1.wr_req;
    // A read and write raised together forward only the read; the write waits
    always_comb begin
        sel = (state == LOCKED || !(req0 || req1)) ? owner :
              (req0 && req1) ? ((FIXED_PRIO != 0 && burst_cnt < MAX_B) ? 1'b0 : ~last_gnt) : req1;
        rd_fwd = ~rst & (sel ? m1.rd_req : m0.rd_req);
        wr_fwd = ~rst & (sel ? m1.wr_req & ~m1.rd_req : m0.wr_req & ~m0.rd_req);
        rd_grant = rd_fwd & s.rd_gnt;
        wr_grant = wr_fwd & s.wr_gnt;
        state_n = ((rd_fwd & ~s.rd_gnt) | (wr_fwd & ~s.wr_gnt)) ? LOCKED : IDLE;
    end
    assign s.rd_req  = rd_fwd;
    assign s.wr_req  = wr_fwd;
    assign s.rd_addr = sel ? m1.rd_addr : m0.rd_addr;
    assign s.rd_be   = sel ? m1.rd_be   : m0.rd_be;
    assign s.wr_addr = sel ? m1.wr_addr : m0.wr_addr;
    assign s.wr_be   = sel ? m1.wr_be   : m0.wr_be;
    assign s.wr_data = sel ? m1.wr_data : m0.wr_data;
    assign m0.rd_gnt = rd_grant & ~sel;
    assign m1.rd_gnt = rd_grant & sel;
    assign m0.wr_gnt = wr_grant & ~sel;
    assign m1.wr_gnt = wr_grant & sel;
    // Read data follows the master granted last cycle, not the current owner
    assign m0.rd_data = (rd_valid && !rd_owner) ? s.rd_data : '0;
    assign m1.rd_data = (rd_valid && rd_owner) ? s.rd_data : '0;
    assign o_owner = owner;
    assign o_busy  = (state == LOCKED);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            burst_cnt <= 8'd0;
            rd_owner  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= sel;
            rd_valid <= rd_grant;
            if (rd_grant)
                rd_owner <= sel;
            if (rd_grant || wr_grant) begin
                last_gnt  <= sel;
                burst_cnt <= (sel != last_gnt) ? 8'd1 : burst_cnt + {7'd0, burst_cnt != 8'hFF};
            end
        end
    end
endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// tb_naive_bus_arbiter2: scoreboard bench for round-robin, stall lock, burst guard and reset
module tb_naive_bus_arbiter2;
    typedef struct {bit m; bit rd; logic [31:0] addr; logic [31:0] data;} exp_t;
    logic clk = 1'b0;
    logic rst, gnt_en;
    logic a_owner, a_busy, b_owner, b_busy;
    int checks = 0, errors = 0;
    exp_t qa[$];
    bit   qb[$];
    bit   pend, pm;
    logic [31:0] pd;
    naive_bus a0(), a1(), as(), b0(), b1(), bs();
    naive_bus_arbiter2 #(.FIXED_PRIO(0), .MAX_BURST(8)) dut_a (
        .clk(clk), .rst(rst), .m0(a0), .m1(a1), .s(as), .o_owner(a_owner), .o_busy(a_busy));
    naive_bus_arbiter2 #(.FIXED_PRIO(1), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst(rst), .m0(b0), .m1(b1), .s(bs), .o_owner(b_owner), .o_busy(b_busy));
    always #5 clk = ~clk;
    function automatic logic [31:0] rd_val(input logic [31:0] addr);
        return addr == 32'h1000 ? 32'hDEADBEEF : addr == 32'h20 ? 32'h12345678 : addr ^ 32'h5A5A0000;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic idle_all;
        {a0.rd_req, a0.wr_req, a1.rd_req, a1.wr_req, b0.rd_req, b0.wr_req, b1.rd_req, b1.wr_req} = '0;
        {a0.rd_addr, a0.wr_addr, a1.rd_addr, a1.wr_addr, b0.rd_addr, b0.wr_addr, b1.rd_addr, b1.wr_addr} = '0;
        {a0.rd_be, a0.wr_be, a1.rd_be, a1.wr_be, b0.rd_be, b0.wr_be, b1.rd_be, b1.wr_be} = '1;
        {a0.wr_data, a1.wr_data, b0.wr_data, b1.wr_data} = '0;
    endtask
    // Slave models: a grants under gnt_en and returns data a cycle later, b always grants
    assign as.rd_gnt = as.rd_req & gnt_en;
    assign as.wr_gnt = as.wr_req & gnt_en;
    always @(posedge clk)
        if (as.rd_req && as.rd_gnt)
            as.rd_data <= rd_val(as.rd_addr);
    assign bs.rd_gnt  = bs.rd_req;
    assign bs.wr_gnt  = bs.wr_req;
    assign bs.rd_data = '0;
    always @(negedge clk) begin
        logic g0, g1;
        exp_t e;
        if (pend && !rst) begin
            chk("rd_data_m0", a0.rd_data, pm ? 32'h0 : pd);
            chk("rd_data_m1", a1.rd_data, pm ? pd : 32'h0);
        end else if (!rst) begin
            chk("rd_idle_m0", a0.rd_data, 32'h0);
            chk("rd_idle_m1", a1.rd_data, 32'h0);
        end
        pend = 1'b0;
        g0 = a0.rd_gnt | a0.wr_gnt;
        g1 = a1.rd_gnt | a1.wr_gnt;
        if (g0 | g1) begin
            if (qa.size() == 0)
                chk("a_gnt_unexpected", 32'({g1, g0}), 32'h0);
            else begin
                e = qa.pop_front();
                chk("a_gnt_who", 32'({g1, g0}), e.m ? 32'd2 : 32'd1);
                if (e.rd) begin
                    chk("a_gnt_rd", 32'(e.m ? a1.rd_gnt : a0.rd_gnt), 32'd1);
                    chk("a_rd_addr", as.rd_addr, e.addr);
                    pend = 1'b1;
                    pm = e.m;
                    pd = e.data;
                end else begin
                    chk("a_gnt_wr", 32'(e.m ? a1.wr_gnt : a0.wr_gnt), 32'd1);
                    chk("a_wr_addr", as.wr_addr, e.addr);
                end
            end
        end
    end
    always @(negedge clk) begin
        logic g0, g1;
        g0 = b0.wr_gnt;
        g1 = b1.wr_gnt;
        if (g0 | g1) begin
            if (qb.size() == 0)
                chk("b_gnt_unexpected", 32'({g1, g0}), 32'h0);
            else
                chk("b_gnt_who", 32'({g1, g0}), qb.pop_front() ? 32'd2 : 32'd1);
        end
    end
    initial begin
        rst = 1'b1;
        gnt_en = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_owner", 32'(a_owner), 32'h0);
        chk("rst_busy", 32'(a_busy), 32'h0);
        chk("rst_b_owner", 32'(b_owner), 32'h0);
        chk("rst_rd_data", a0.rd_data | a1.rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        gnt_en = 1'b1;
        a0.wr_req = 1'b1; a0.wr_addr = 32'h100;
        a1.wr_req = 1'b1; a1.wr_addr = 32'h200;
        b0.wr_req = 1'b1; b1.wr_req = 1'b1;
        for (int i = 0; i < 8; i++)
            qa.push_back('{bit'(i % 2), 1'b0, (i % 2) ? 32'h200 : 32'h100, 32'h0});
        for (int i = 0; i < 20; i++)
            qb.push_back(i % 5 == 4);
        repeat (8) step();
        a0.wr_req = 1'b0; a1.wr_req = 1'b0;
        repeat (12) step();
        b0.wr_req = 1'b0; b1.wr_req = 1'b0;
        a0.rd_req = 1'b1; a0.rd_addr = 32'h1000;
        qa.push_back('{1'b0, 1'b1, 32'h1000, 32'hDEADBEEF});
        @(negedge clk);
        chk("single_rd_addr", as.rd_addr, 32'h1000);
        step();
        a0.rd_req = 1'b0;
        step();
        gnt_en = 1'b0;
        a1.rd_req = 1'b1; a1.rd_addr = 32'h20;
        @(negedge clk);
        chk("lock_busy_c0", 32'(a_busy), 32'h0);
        step();
        a0.wr_req = 1'b1; a0.wr_addr = 32'h300;
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                gnt_en = 1'b1;
                qa.push_back('{1'b1, 1'b1, 32'h20, 32'h12345678});
                qa.push_back('{1'b0, 1'b0, 32'h300, 32'h0});
            end
            @(negedge clk);
            chk("lock_busy", 32'(a_busy), 32'h1);
            chk("lock_rd_addr", as.rd_addr, 32'h20);
            chk("lock_owner", 32'(a_owner), 32'h1);
            step();
        end
        a1.rd_req = 1'b0;
        @(negedge clk);
        chk("unlock_busy", 32'(a_busy), 32'h0);
        chk("unlock_m0_gnt", 32'(a0.wr_gnt), 32'h1);
        step();
        a0.wr_req = 1'b0;
        step();
        gnt_en = 1'b0;
        a0.rd_req = 1'b1; a0.rd_addr = 32'h40;
        step();
        @(negedge clk);
        chk("pre_rst_busy", 32'(a_busy), 32'h1);
        chk("pre_rst_owner", 32'(a_owner), 32'h0);
        #2;
        gnt_en = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(a_busy), 32'h0);
        chk("async_rst_owner", 32'(a_owner), 32'h0);
        chk("async_rst_gnt", 32'({a0.rd_gnt, a0.wr_gnt, a1.rd_gnt, a1.wr_gnt}), 32'h0);
        chk("async_rst_rd_data", a0.rd_data | a1.rd_data, 32'h0);
        a0.rd_req = 1'b0;
        a0.wr_req = 1'b1; a0.wr_addr = 32'h500;
        a1.wr_req = 1'b1; a1.wr_addr = 32'h600;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.push_back('{1'b0, 1'b0, 32'h500, 32'h0});
        @(negedge clk);
        chk("post_rst_first_m0", 32'(a0.wr_gnt), 32'h1);
        step();
        idle_all();
        repeat (2) step();
        chk("qa_drained", qa.size(), 32'h0);
        chk("qb_drained", qb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
